// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU shape pipeline: coordinate width,
// rasteriser state encoding and the primitive IDs used by the control unit.
package gpu_pkg;

    // Coordinate width in bits; 10 bits covers a 640x480 frame.
    localparam int COORD_W = 10;

    // Line rasteriser sequencing states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EMIT    = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        DONE    = 3'd4
    } raster_state_t;

    // Primitive encodings carried in the shape FIFO.
    typedef enum logic [1:0] {
        SHAPE_LINE     = 2'd0,
        SHAPE_TRIANGLE = 2'd1,
        SHAPE_ARC      = 2'd2,
        SHAPE_CLEAR    = 2'd3
    } shape_id_t;

endpackage

// File: rtl/line_raster_if.sv
// Handshake and coordinate bundle between the control unit (master) and
// the line rasteriser (slave).
interface line_raster_if #(
    parameter int COORD_W = gpu_pkg::COORD_W
);

    logic               enable;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               data_ready;
    logic               line_done;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;

    modport master (
        output enable, x0, y0, x1, y1,
        input  data_ready, line_done, pix_x, pix_y
    );

    modport slave (
        input  enable, x0, y0, x1, y1,
        output data_ready, line_done, pix_x, pix_y
    );

endinterface

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: from the current point and error term,
// produce the next point and error. Shared by the line and arc paths.
// sx/sy are direction flags: 0 steps by +1, 1 steps by -1.
module bresenham_step #(
    parameter int COORD_W = 10
) (
    input  logic                      [COORD_W-1:0] cur_x,
    input  logic                      [COORD_W-1:0] cur_y,
    input  logic signed               [COORD_W+1:0] err,
    input  logic signed               [COORD_W+1:0] dx,
    input  logic signed               [COORD_W+1:0] dy,
    input  logic                                    sx,
    input  logic                                    sy,
    output logic                      [COORD_W-1:0] next_x,
    output logic                      [COORD_W-1:0] next_y,
    output logic signed               [COORD_W+1:0] next_err
);

    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    logic signed [COORD_W+2:0] e2;
    logic signed [COORD_W+2:0] dx_ext;
    logic signed [COORD_W+2:0] dy_ext;
    logic                      step_x;
    logic                      step_y;

    // Both decisions compare against the pre-step error; both updates may apply.
    always_comb begin
        // NOTE: blocking assignments in combinational logic, so later lines see
        // the values just computed (next_err accumulates both updates in order).
        e2       = {err, 1'b0};
        dx_ext   = {dx[COORD_W+1], dx};
        dy_ext   = {dy[COORD_W+1], dy};
        step_x   = (e2 >= dy_ext);
        step_y   = (e2 <= dx_ext);
        next_err = err;
        next_x   = cur_x;
        next_y   = cur_y;
        if (step_x) begin
            next_err = next_err + dy;
            next_x   = sx ? (cur_x - ONE) : (cur_x + ONE);
        end
        if (step_y) begin
            next_err = next_err + dx;
            next_y   = sy ? (cur_y - ONE) : (cur_y + ONE);
        end
    end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: latches a segment on enable, then hands out one
// pixel per enable low/high handshake from the control unit, and finally
// raises line_done. All outputs are registered.
module line_raster
    import gpu_pkg::*;
#(
    parameter int COORD_W = gpu_pkg::COORD_W
) (
    input  logic          clk,
    input  logic          nreset,
    line_raster_if.slave  bus
);

    localparam int EW = COORD_W + 2;

    raster_state_t        state_q, state_d;
    logic signed [EW-1:0] dx_q, dx_d;
    logic signed [EW-1:0] dy_q, dy_d;
    logic signed [EW-1:0] err_q, err_d;
    logic                 sx_q, sx_d;
    logic                 sy_q, sy_d;
    logic [COORD_W-1:0]   cur_x_q, cur_x_d;
    logic [COORD_W-1:0]   cur_y_q, cur_y_d;
    logic [COORD_W-1:0]   end_x_q, end_x_d;
    logic [COORD_W-1:0]   end_y_q, end_y_d;
    logic [COORD_W-1:0]   pix_x_q, pix_x_d;
    logic [COORD_W-1:0]   pix_y_q, pix_y_d;
    logic                 data_ready_q, data_ready_d;
    logic                 line_done_q, line_done_d;

    logic [COORD_W-1:0]   abs_dx;
    logic [COORD_W-1:0]   abs_dy;
    logic signed [EW-1:0] dx_init;
    logic signed [EW-1:0] dy_init;
    logic [COORD_W-1:0]   step_x;
    logic [COORD_W-1:0]   step_y;
    logic signed [EW-1:0] step_err;
    logic                 at_end;

    // Segment setup terms from the FIFO head, used only when leaving IDLE.
    assign abs_dx  = (bus.x1 >= bus.x0) ? (bus.x1 - bus.x0) : (bus.x0 - bus.x1);
    assign abs_dy  = (bus.y1 >= bus.y0) ? (bus.y1 - bus.y0) : (bus.y0 - bus.y1);
    assign dx_init = signed'({2'b00, abs_dx});
    assign dy_init = -signed'({2'b00, abs_dy});
    assign at_end  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

    bresenham_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .cur_x    (cur_x_q),
        .cur_y    (cur_y_q),
        .err      (err_q),
        .dx       (dx_q),
        .dy       (dy_q),
        .sx       (sx_q),
        .sy       (sy_q),
        .next_x   (step_x),
        .next_y   (step_y),
        .next_err (step_err)
    );

    // Next-state and next-output logic for the handshake sequencer.
    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        err_d        = err_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        end_x_d      = end_x_q;
        end_y_d      = end_y_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    dx_d    = dx_init;
                    dy_d    = dy_init;
                    err_d   = dx_init + dy_init;
                    sx_d    = (bus.x1 < bus.x0);
                    sy_d    = (bus.y1 < bus.y0);
                    cur_x_d = bus.x0;
                    cur_y_d = bus.y0;
                    end_x_d = bus.x1;
                    end_y_d = bus.y1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.enable) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.enable) begin
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        cur_x_d = step_x;
                        cur_y_d = step_y;
                        err_d   = step_err;
                        state_d = EMIT;
                    end
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Moore outputs decoded from the state being entered.
        data_ready_d = (state_d == EMIT);
        line_done_d  = (state_d == DONE);
        if (state_d == EMIT) begin
            pix_x_d = cur_x_d;
            pix_y_d = cur_y_d;
        end
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            dx_q         <= '0;
            dy_q         <= '0;
            err_q        <= '0;
            sx_q         <= 1'b0;
            sy_q         <= 1'b0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            end_x_q      <= '0;
            end_y_q      <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            data_ready_q <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            err_q        <= err_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            end_x_q      <= end_x_d;
            end_y_q      <= end_y_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            data_ready_q <= data_ready_d;
            line_done_q  <= line_done_d;
        end
    end

    assign bus.data_ready = data_ready_q;
    assign bus.line_done  = line_done_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;

endmodule

// File: tb/tb_line_raster.sv
// Self-checking bench for line_raster: emulates the control unit handshake,
// runs a table of lines with hand-computed pixel sequences, then directed
// sequences for reset, stalls and endpoint changes mid-line.
module tb_line_raster;
    import gpu_pkg::*;

    localparam int W = 10;

    logic clk    = 1'b0;
    logic nreset = 1'b0;

    line_raster_if #(.COORD_W(W)) bus ();

    line_raster #(.COORD_W(W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string name;
        int    x0, y0, x1, y1;
        int    first;
        int    npix;
    } vec_t;

    vec_t vecs[5];

    // Expected pixels for the table, concatenated; vecs[i].first indexes here.
    int exp_x[17] = '{2, 3, 4, 5,  3, 2, 2, 1, 1,  7,  4, 3, 2, 1,  0, 0, 0};
    int exp_y[17] = '{5, 5, 5, 5,  3, 4, 5, 6, 7,  7,  4, 3, 2, 1,  2, 1, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int x0, input int y0, input int x1, input int y1);
        bus.x0 = W'(x0);
        bus.y0 = W'(y0);
        bus.x1 = W'(x1);
        bus.y1 = W'(y1);
    endtask

    // Waits (bounded) for data_ready or line_done, sampling on falling edges.
    task automatic wait_event();
        @(negedge clk);
        for (int i = 0; i < 10 && !(bus.data_ready || bus.line_done); i++) begin
            @(negedge clk);
        end
    endtask

    // Request one pixel, check it, then drop enable for two edges like OUTPIX.
    task automatic step_pixel(input string name, input int ex, input int ey);
        bus.enable = 1'b1;
        wait_event();
        check({name, "_ready"}, 32'(bus.data_ready), 1);
        check({name, "_excl"}, 32'(bus.line_done), 0);
        check({name, "_x"}, 32'(bus.pix_x), ex);
        check({name, "_y"}, 32'(bus.pix_y), ey);
        bus.enable = 1'b0;
        @(negedge clk);
        check({name, "_pulse"}, 32'(bus.data_ready), 0);
        @(negedge clk);
    endtask

    // Request past the last pixel; expect line_done, then release it.
    task automatic finish_line(input string name);
        bus.enable = 1'b1;
        wait_event();
        check({name, "_done"}, 32'(bus.line_done), 1);
        check({name, "_done_excl"}, 32'(bus.data_ready), 0);
        bus.enable = 1'b0;
        @(negedge clk);
        check({name, "_done_clr"}, 32'(bus.line_done), 0);
        check({name, "_idle"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{name: "horiz",  x0: 2, y0: 5, x1: 5, y1: 5, first: 0,  npix: 4};
        vecs[1] = '{name: "steep",  x0: 3, y0: 3, x1: 1, y1: 7, first: 4,  npix: 5};
        vecs[2] = '{name: "degen",  x0: 7, y0: 7, x1: 7, y1: 7, first: 9,  npix: 1};
        vecs[3] = '{name: "diag",   x0: 4, y0: 4, x1: 1, y1: 1, first: 10, npix: 4};
        vecs[4] = '{name: "vert",   x0: 0, y0: 2, x1: 0, y1: 0, first: 14, npix: 3};

        bus.enable = 1'b0;
        load(0, 0, 0, 0);

        // Reset values while nreset is held low.
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.data_ready), 0);
        check("rst_done", 32'(bus.line_done), 0);
        check("rst_pix_x", 32'(bus.pix_x), 0);
        check("rst_pix_y", 32'(bus.pix_y), 0);
        nreset = 1'b1;
        @(negedge clk);

        // Table-driven lines.
        for (int i = 0; i < 5; i++) begin
            load(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
            for (int k = 0; k < vecs[i].npix; k++) begin
                step_pixel($sformatf("%s_p%0d", vecs[i].name, k),
                           exp_x[vecs[i].first + k], exp_y[vecs[i].first + k]);
            end
            finish_line(vecs[i].name);
        end

        // Stall: enable held high after EMIT must not step, then a long low stall.
        load(0, 0, 3, 1);
        bus.enable = 1'b1;
        wait_event();
        check("stall_p0_ready", 32'(bus.data_ready), 1);
        check("stall_p0_x", 32'(bus.pix_x), 0);
        check("stall_p0_y", 32'(bus.pix_y), 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold_hi_ready_%0d", c), 32'(bus.data_ready), 0);
            check($sformatf("hold_hi_pix_%0d", c), 32'({bus.pix_x, bus.pix_y}), 0);
        end
        bus.enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("stall_ready_%0d", c), 32'(bus.data_ready), 0);
            check($sformatf("stall_pix_%0d", c), 32'({bus.pix_x, bus.pix_y}), 0);
        end
        step_pixel("stall_p1", 1, 0);
        step_pixel("stall_p2", 2, 1);
        step_pixel("stall_p3", 3, 1);
        finish_line("stall");

        // Endpoint change mid-line is ignored; new endpoints load on the next line.
        load(2, 5, 5, 5);
        step_pixel("chg_p0", 2, 5);
        bus.x1 = W'(2);
        bus.y1 = W'(8);
        step_pixel("chg_p1", 3, 5);
        step_pixel("chg_p2", 4, 5);
        step_pixel("chg_p3", 5, 5);
        finish_line("chg");
        step_pixel("new_p0", 2, 5);
        step_pixel("new_p1", 2, 6);
        step_pixel("new_p2", 2, 7);
        step_pixel("new_p3", 2, 8);
        finish_line("new");

        // Reset asserted while in EMIT: outputs clear immediately.
        load(2, 5, 5, 5);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_pre_ready", 32'(bus.data_ready), 1);
        nreset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.data_ready), 0);
        check("mid_rst_done", 32'(bus.line_done), 0);
        check("mid_rst_pix", 32'({bus.pix_x, bus.pix_y}), 0);
        @(negedge clk);
        bus.enable = 1'b0;
        nreset = 1'b1;
        @(negedge clk);
        check("post_rst_state", 32'(dut.state_q), 32'(IDLE));
        check("post_rst_ready", 32'(bus.data_ready), 0);
        step_pixel("rec_p0", 2, 5);
        step_pixel("rec_p1", 3, 5);
        step_pixel("rec_p2", 4, 5);
        step_pixel("rec_p3", 5, 5);
        finish_line("rec");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
